led_seq_ctrl: RTL

- Command-driven sequencer for the board LED output. It replaces a free-running toggle with controlled modes: off, solid, continuous blink, and counted burst.
- Sits between the top level and the `led` pin. A requester (host logic or a debug FSM) issues one command at a time over a valid/ready handshake.
- A millisecond-scale tick from an internal prescaler times every LED transition.

---
 rtl/led_pkg.sv | 19 +
 rtl/tick_gen.sv | 29 ++
 rtl/led_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: command modes, FSM states and default clock rates.
package led_pkg;

    localparam int unsigned DEF_CLK_HZ  = 100_000_000;
    localparam int unsigned DEF_TICK_HZ = 1_000;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOLID = 2'd1,
        BLINK = 2'd2,
        BURST = 2'd3
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks; clr restarts the count from zero.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;

    // tick is registered so it is high exactly while pre == DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= (pre == PW'(DIV - 1)) ? '0 : pre + PW'(1);
            tick <= (pre == PW'(DIV - 2));
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: off, solid, continuous blink and counted burst,
// timed by a prescaled tick. Any accepted command pre-empts the current one.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ = DEF_TICK_HZ,
    parameter int unsigned PER_W   = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    if (DIV < 2) begin : g_div_chk
        $error("led_seq_ctrl: CLK_HZ/TICK_HZ must be >= 2");
    end

    state_t           state;
    logic [PER_W-1:0] per;
    logic [PER_W-1:0] tcnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bcnt;
    logic             tick;
    logic             accept;

    assign cmd_ready = 1'b1;
    assign accept    = cmd_valid && cmd_ready;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            per   <= '0;
            tcnt  <= '0;
            cnt   <= '0;
            bcnt  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                per  <= (cmd_period == '0) ? PER_W'(1) : cmd_period;
                cnt  <= cmd_count;
                tcnt <= '0;
                bcnt <= '0;
                case (cmd_mode)
                    MODE_OFF: begin
                        state <= IDLE;
                        led   <= 1'b0;
                        busy  <= 1'b0;
                    end
                    MODE_SOLID: begin
                        state <= SOLID;
                        led   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        state <= BLINK;
                        led   <= 1'b1;
                        busy  <= 1'b1;
                    end
                    default: begin
                        // a zero-length burst finishes immediately
                        if (cmd_count == '0) begin
                            state <= IDLE;
                            led   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= BURST;
                            led   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                endcase
            end else if ((state == BLINK || state == BURST) && tick) begin
                if (tcnt == per - PER_W'(1)) begin
                    tcnt <= '0;
                    if (led) begin
                        led <= 1'b0;
                        if (state == BURST) begin
                            bcnt <= bcnt + CNT_W'(1);
                        end
                    end else if (state == BURST && bcnt == cnt) begin
                        // burst ends after the off half of its last blink
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        led <= 1'b1;
                    end
                end else begin
                    tcnt <= tcnt + PER_W'(1);
                end
            end
        end
    end

endmodule
